anton_neopixel_pixel_encoder: RTL
=================================

// Module: anton_neopixel_pixel_encoder
// PURPOSE
//  Downstream of the stream logic. Prefetches pixel data from the frame buffer and converts it to the serial NeoPixel waveform.
//  Follows the stream logic's indices (bit_pattern_index, pixel_bit_index, pixel_index) and drives the LED data pin.
//  Double-buffered: the next pixel is fetched while the current one shifts out.
// PARAMETERS
//  BUFFER_END   `BUFFER_END_DEFAULT  last valid byte address of the frame buffer
//  BUFFER_BITS  `CLOG2(BUFFER_END+1) localparam, buffer address width
//  T0H_STEPS    2                    high sub-steps (of 8) for a '0' bit, 312.5ns
//  T1H_STEPS    5                    high sub-steps (of 8) for a '1' bit, 781.25ns
// PORTS
//  clk6_4mhz          in   1            6.4MHz stream clock, all logic on posedge
//  reset              in   1            synchronous, active-high
//  reg_ctrl_32bit     in   1            1=4 bytes/pixel (R,G,B,unused), 0=1 byte/pixel RGB332
//  stream_output      in   1            stream logic is in transmit state
//  stream_reset       in   1            stream logic is in reset (latch) state
//  bit_pattern_index  in   3            sub-step 0..7 within the current bit
//  pixel_bit_index    in   5            bit 0..23 within the current pixel
//  pixel_index        in   BUFFER_BITS  byte address of the current pixel
//  pixel_index_max    in   BUFFER_BITS  last reachable pixel address
//  buf_rd_en          out  1            buffer read strobe
//  buf_rd_addr        out  BUFFER_BITS  buffer read address
//  buf_rd_data        in   8            read data, valid 1 cycle after buf_rd_en
//  neopixel_data      out  1            serial LED data line
//  underrun           out  1            sticky: a pixel was needed before its fetch completed
// BEHAVIOUR
//  Reset: neopixel_data=0, underrun=0, buf_rd_en=0, buf_rd_addr=0, cur=0, nxt=0, nxt_valid=0, FSM=IDLE.
//  Load event L = stream_output && bit_pattern_index==0 && pixel_bit_index==0.
//  At L: cur<=nxt, nxt_valid<=0. A fetch of the following pixel starts from fetch address F.
//    32bit mode: F = pixel_index_equiv==pixel_index_max ? 0 : pixel_index+4.
//      pixel_index_equiv = {pixel_index[BUFFER_BITS-1:2],2'b11}.
//    8bit mode: F = pixel_index==pixel_index_max ? 0 : pixel_index+1.
//    All address arithmetic is modulo 2^BUFFER_BITS.
//  At L with nxt_valid==0: underrun<=1, cur<=24'h0 (black pixel sent). underrun clears only on reset.
//  While stream_reset && nxt_valid==0 && FSM==IDLE: start a fetch with F=0 (prefetch the first pixel).
//  reg_ctrl_32bit is sampled when a fetch starts and held for that fetch.
//  Fetch FSM: IDLE -> RD0 -> RD1 -> RD2 -> CAP -> IDLE (32bit); IDLE -> RD0 -> CAP -> IDLE (8bit).
//    RDn: buf_rd_en=1, buf_rd_addr=F+n. Data of RDn is captured in the following state.
//    CAP: capture the last byte, nxt_valid<=1, buf_rd_en=0.
//    Fetch latency: 4 cycles (32bit) or 2 cycles (8bit), well under the 192-cycle pixel time.
//    Byte 3 of a 32bit pixel is never read.
//  Pixel assembly (24b, wire order GRB, MSB first):
//    32bit: nxt = {G=byte1, R=byte0, B=byte2}.
//    8bit, byte d: r=d[7:5], g=d[4:2], b=d[1:0];
//      R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}.
//  Bit select: bit = L ? nxt[23] : cur[23-pixel_bit_index]. Values 24..31 of pixel_bit_index give bit 0.
//  Waveform: neopixel_data is registered and lags the indices by 1 cycle.
//    Value = stream_output && (bit_pattern_index < (bit ? T1H_STEPS : T0H_STEPS)).
//    When !stream_output, neopixel_data is 0 next cycle. stream_reset therefore gives a low latch period.
//  Reset mid-operation: any in-flight fetch is aborted and all state returns to its reset values. neopixel_data is 0 the next cycle.
//  An L in the same cycle as CAP is an underrun (the CAP data lands in nxt for the next pixel).
// TESTING
//  1. 32bit, buffer[0..2]=FF,00,A5, max=3, reset phase then transmit
//     -> bits 0x00FFA5 sent MSB first.
//     -> each '1' gives 5 cycles high / 3 low; each '0' gives 2 high / 6 low; underrun=0.
//  2. 8bit, buffer[0]=E0 -> G=00, R=FF, B=00.
//     -> buffer[1]=03 -> B=FF only.
//     -> exactly one buf_rd_en pulse per pixel.
//  3. Wrap: 8bit, max=2 -> fetch addresses 0,1,2,0.
//     -> after pixel 2's L, F=0; the first pixel of the next frame equals buffer[0].
//  4. Underrun: release reset directly into stream_output with pixel_index=0
//     -> underrun=1, 24 '0' bits (2H/6L).
//     -> pixel 1 is correct; underrun stays 1.
//  5. Assert reset at bit 10 of a pixel, mid-fetch
//     -> next cycle: neopixel_data=0, buf_rd_en=0, underrun=0, FSM=IDLE.
//  6. Timing: buf_rd_data changes only in the cycle after buf_rd_en.
//     -> nxt_valid rises 4 cycles (32bit) or 2 cycles (8bit) after fetch start.

Source files
------------

// File: rtl/anton_neopixel_pixel_encoder.sv
// Prefetching NeoPixel pixel encoder: fetches the next pixel from the frame buffer
// while the current one is serialised onto the LED data line.
module anton_neopixel_pixel_encoder #(
  parameter int BUFFER_END = 1023,
  parameter int T0H_STEPS  = 2,
  parameter int T1H_STEPS  = 5,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   reset,
  input  logic                   reg_ctrl_32bit,
  input  logic                   stream_output,
  input  logic                   stream_reset,
  input  logic [2:0]             bit_pattern_index,
  input  logic [4:0]             pixel_bit_index,
  input  logic [BUFFER_BITS-1:0] pixel_index,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  output logic                   buf_rd_en,
  output logic [BUFFER_BITS-1:0] buf_rd_addr,
  input  logic [7:0]             buf_rd_data,
  output logic                   neopixel_data,
  output logic                   underrun
);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP} state_t;

  state_t                 state_q, state_d;
  logic [BUFFER_BITS-1:0] fetch_addr_q, fetch_addr_d;
  logic                   mode_q, mode_d;
  logic [7:0]             byte0_q, byte0_d;
  logic [7:0]             byte1_q, byte1_d;
  logic [23:0]            cur_q, cur_d;
  logic [23:0]            nxt_q, nxt_d;
  logic                   nxt_valid_q, nxt_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   neopixel_q, neopixel_d;

  logic                   load;
  logic [BUFFER_BITS-1:0] pixel_equiv;
  logic [BUFFER_BITS-1:0] next_addr;
  logic [4:0]             bit_sel;
  logic                   cur_bit;
  logic                   tx_bit;

  // RGB332 expansion replicates each channel's MSBs into the low bits; wire order is GRB.
  function automatic logic [23:0] expand332(input logic [7:0] d);
    logic [2:0] r, g;
    logic [1:0] b;
    r = d[7:5];
    g = d[4:2];
    b = d[1:0];
    return {g, g, g[2:1], r, r, r[2:1], b, b, b, b};
  endfunction

  always_comb begin
    load        = stream_output && (bit_pattern_index == 3'd0) && (pixel_bit_index == 5'd0);
    pixel_equiv = {pixel_index[BUFFER_BITS-1:2], 2'b11};
    if (reg_ctrl_32bit) begin
      next_addr = (pixel_equiv == pixel_index_max) ? '0 : pixel_index + BUFFER_BITS'(4);
    end else begin
      next_addr = (pixel_index == pixel_index_max) ? '0 : pixel_index + BUFFER_BITS'(1);
    end

    bit_sel = 5'd23 - pixel_bit_index;
    cur_bit = (pixel_bit_index < 5'd24) ? cur_q[bit_sel] : 1'b0;
    // A stale nxt must not leak out when the load is an underrun.
    tx_bit  = load ? (nxt_valid_q & nxt_q[23]) : cur_bit;
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mode_d       = mode_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    nxt_valid_d  = nxt_valid_q;
    underrun_d   = underrun_q;
    buf_rd_en    = 1'b0;
    buf_rd_addr  = '0;

    neopixel_d = stream_output &&
                 (int'(bit_pattern_index) < (tx_bit ? T1H_STEPS : T0H_STEPS));

    if (load) begin
      nxt_valid_d = 1'b0;
      if (nxt_valid_q) begin
        cur_d = nxt_q;
      end else begin
        cur_d      = 24'h0;
        underrun_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          fetch_addr_d = next_addr;
          mode_d       = reg_ctrl_32bit;
          state_d      = S_RD0;
        end else if (stream_reset && !nxt_valid_q) begin
          fetch_addr_d = '0;
          mode_d       = reg_ctrl_32bit;
          state_d      = S_RD0;
        end
      end
      S_RD0: begin
        buf_rd_en   = 1'b1;
        buf_rd_addr = fetch_addr_q;
        state_d     = mode_q ? S_RD1 : S_CAP;
      end
      S_RD1: begin
        buf_rd_en   = 1'b1;
        buf_rd_addr = fetch_addr_q + BUFFER_BITS'(1);
        byte0_d     = buf_rd_data;
        state_d     = S_RD2;
      end
      S_RD2: begin
        buf_rd_en   = 1'b1;
        buf_rd_addr = fetch_addr_q + BUFFER_BITS'(2);
        byte1_d     = buf_rd_data;
        state_d     = S_CAP;
      end
      S_CAP: begin
        // Wins over a coincident load: the captured pixel goes out next time.
        nxt_d       = mode_q ? {byte1_q, byte0_q, buf_rd_data} : expand332(buf_rd_data);
        nxt_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk6_4mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      mode_q       <= 1'b0;
      byte0_q      <= 8'h0;
      byte1_q      <= 8'h0;
      cur_q        <= 24'h0;
      nxt_q        <= 24'h0;
      nxt_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      neopixel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mode_q       <= mode_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      nxt_valid_q  <= nxt_valid_d;
      underrun_q   <= underrun_d;
      neopixel_q   <= neopixel_d;
    end
  end

  assign neopixel_data = neopixel_q;
  assign underrun      = underrun_q;

endmodule
